// File: rtl/burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : burst_mem_responder
// Description : Memory-side responder for a 64-bit, 4-beat physical-memory
//               burst interface. Serves 256-bit line reads and writes from an
//               internal line array after a programmable access latency and
//               flags initiator protocol violations.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_mem_responder #(
    parameter int IDX_BITS = 8,   // line-index width, 2**IDX_BITS lines
    parameter int LATENCY  = 4    // capture-to-first-beat cycles, 1..15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pmem_addr,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [63:0] pmem_wdata,
    output logic [63:0] pmem_rdata,
    output logic        pmem_resp,
    output logic        proto_err
);

    localparam int         c_DEPTH    = 1 << IDX_BITS;
    localparam logic [3:0] c_LAT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_BURST = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [3:0]          r_lat_cnt;
    logic [1:0]          r_beat;
    logic [IDX_BITS-1:0] r_idx;
    logic                r_is_write;
    logic                r_proto_err;
    logic [255:0]        r_shadow;

    // Line array stored as 64-bit beats, addressed {line index, beat}
    logic [63:0]         r_mem [0:c_DEPTH*4-1];

    logic                w_req;
    logic                w_op_live;
    logic                w_enter_burst;
    logic [255:0]        w_line;
    logic                w_unused_addr_bits;

    assign w_req     = pmem_read | pmem_write;
    // The request signal matching the captured operation must stay high
    assign w_op_live = r_is_write ? pmem_write : pmem_read;
    assign w_enter_burst = (r_state == c_WAIT) && (r_lat_cnt == 4'd0);
    assign w_line = {r_mem[{r_idx, 2'd3}], r_mem[{r_idx, 2'd2}],
                     r_mem[{r_idx, 2'd1}], r_mem[{r_idx, 2'd0}]};
    // Offset bits and bits above the index simply alias
    assign w_unused_addr_bits = ^{pmem_addr[31:IDX_BITS+5], pmem_addr[4:0]};

    // Transaction sequencing, counters and the sticky protocol-error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_IDLE;
            r_lat_cnt   <= 4'd0;
            r_beat      <= 2'd0;
            r_idx       <= '0;
            r_is_write  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        r_idx      <= pmem_addr[IDX_BITS+4:5];
                        r_is_write <= ~pmem_read;   // read wins on conflict
                        r_lat_cnt  <= c_LAT_INIT;
                        r_state    <= c_WAIT;
                        if (pmem_read && pmem_write) begin
                            r_proto_err <= 1'b1;
                        end
                    end
                end
                c_WAIT: begin
                    if (!w_op_live) begin
                        r_proto_err <= 1'b1;
                    end
                    if (r_lat_cnt == 4'd0) begin
                        r_beat  <= 2'd0;
                        r_state <= c_BURST;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                c_BURST: begin
                    if (!w_op_live) begin
                        r_proto_err <= 1'b1;
                    end
                    r_beat <= r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    // Turnaround cycle: still-held requests are ignored
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Line storage and read shadow; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if ((r_state == c_BURST) && r_is_write) begin
            r_mem[{r_idx, r_beat}] <= pmem_wdata;
        end
        if (w_enter_burst && !r_is_write) begin
            r_shadow <= w_line;
        end
    end

    // Beat strobe and read data, forced to zero outside read bursts
    always_comb begin
        pmem_resp  = (r_state == c_BURST);
        pmem_rdata = 64'd0;
        if ((r_state == c_BURST) && !r_is_write) begin
            pmem_rdata = r_shadow[{r_beat, 6'd0} +: 64];
        end
    end

    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_burst_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_mem_responder
// Description : Self-checking bench for burst_mem_responder. Two instances
//               (LATENCY=4 and LATENCY=1) are checked against a line-level
//               reference model keyed by line index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] ad   [2];
    logic [63:0] wd   [2];
    logic [63:0] rdat [2];
    logic        rsp  [2];
    logic        perr [2];

    int checks   = 0;
    int failures = 0;

    logic [255:0] mdl [int];
    bit           err_exp [2];

    always #5 clk = ~clk;

    burst_mem_responder #(.IDX_BITS(8), .LATENCY(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .pmem_addr(ad[0]), .pmem_read(rd[0]),
        .pmem_write(wr[0]), .pmem_wdata(wd[0]), .pmem_rdata(rdat[0]),
        .pmem_resp(rsp[0]), .proto_err(perr[0])
    );

    burst_mem_responder #(.IDX_BITS(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .pmem_addr(ad[1]), .pmem_read(rd[1]),
        .pmem_write(wr[1]), .pmem_wdata(wd[1]), .pmem_rdata(rdat[1]),
        .pmem_resp(rsp[1]), .proto_err(perr[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model key: one entry per (instance, line index)
    function automatic int key(input int d, input logic [31:0] a);
        return d * 1024 + int'((a / 32) % 256);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // One transaction on instance d, checked cycle by cycle.
    // drop_after: beat index after which the request is released (-1: never)
    // hold: keep the request asserted through the turnaround cycle
    task automatic txn(input int d, input bit is_wr, input logic [31:0] a,
                       input logic [255:0] wline, input bit both,
                       input int drop_after, input bit hold);
        int           lat;
        bit           op_rd;
        logic [255:0] exp_line;
        lat = (d == 1) ? 1 : 4;
        @(posedge clk); #1;
        chk("idle_resp", 64'(rsp[d]), 64'd0);
        ad[d] = a;
        rd[d] = !is_wr || both;
        wr[d] = is_wr || both;
        op_rd = rd[d];
        if (both) err_exp[d] = 1'b1;
        exp_line = op_rd ? mdl[key(d, a)] : 256'd0;
        @(posedge clk); #1;
        for (int i = 0; i < lat; i++) begin
            chk("wait_resp", 64'(rsp[d]), 64'd0);
            chk("wait_rdata", rdat[d], 64'd0);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            chk("beat_resp", 64'(rsp[d]), 64'd1);
            chk("beat_rdata", rdat[d], op_rd ? exp_line[k*64 +: 64] : 64'd0);
            if (!op_rd) wd[d] = wline[k*64 +: 64];
            if (k == drop_after) begin
                rd[d] = 1'b0;
                wr[d] = 1'b0;
                err_exp[d] = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!op_rd) mdl[key(d, a)] = wline;
        chk("done_resp", 64'(rsp[d]), 64'd0);
        chk("done_rdata", rdat[d], 64'd0);
        chk("proto_err", 64'(perr[d]), 64'(err_exp[d]));
        if (!hold) begin
            rd[d] = 1'b0;
            wr[d] = 1'b0;
        end
    endtask

    initial begin
        int           idx_pool [6];
        int           idx;
        bit           do_wr;
        logic [31:0]  a;
        logic [255:0] l;

        idx_pool = '{2, 1, 7, 0, 200, 255};
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = 32'd0; wd[d] = 64'd0;
            err_exp[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_resp", 64'(rsp[d]), 64'd0);
            chk("rst_rdata", rdat[d], 64'd0);
            chk("rst_err", 64'(perr[d]), 64'd0);
        end
        reset_n = 1'b1;

        // Directed write then read of line 0x40
        l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        txn(0, 1'b1, 32'h0000_0040, l, 1'b0, -1, 1'b0);
        txn(0, 1'b0, 32'h0000_0040, 256'd0, 1'b0, -1, 1'b0);

        // Aliased address and nonzero offset reach the same line
        txn(0, 1'b1, 32'h0000_0020, rand_line(), 1'b0, -1, 1'b0);
        txn(0, 1'b0, 32'h0000_203F, 256'd0, 1'b0, -1, 1'b0);

        // Back-to-back reads with the request held through turnaround
        txn(0, 1'b0, 32'h0000_0040, 256'd0, 1'b0, -1, 1'b1);
        txn(0, 1'b0, 32'h0000_0040, 256'd0, 1'b0, -1, 1'b0);

        // LATENCY=1 instance: write then read
        txn(1, 1'b1, 32'h0000_0100, rand_line(), 1'b0, -1, 1'b0);
        txn(1, 1'b0, 32'h0000_0100, 256'd0, 1'b0, -1, 1'b0);

        // Randomized traffic over a small pool of lines
        for (int n = 0; n < 24; n++) begin
            idx   = idx_pool[$urandom_range(0, 5)];
            a     = ($urandom & 32'hFFFF_E01F) | (32'(idx) << 5);
            do_wr = ($urandom_range(0, 1) == 1) || !mdl.exists(key(0, a));
            txn(0, do_wr, a, rand_line(), 1'b0, -1, 1'b0);
        end

        // Protocol violations: conflicting request, then a dropped read
        txn(0, 1'b0, 32'h0000_0040, 256'd0, 1'b1, -1, 1'b0);
        txn(0, 1'b0, 32'h0000_0020, 256'd0, 1'b0, 1, 1'b0);
        txn(0, 1'b0, 32'h0000_0040, 256'd0, 1'b0, -1, 1'b0);

        // Asynchronous reset during a read burst
        @(posedge clk); #1;
        rd[0] = 1'b1;
        ad[0] = 32'h0000_0040;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_resp", 64'(rsp[0]), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_resp", 64'(rsp[0]), 64'd0);
        chk("async_rst_rdata", rdat[0], 64'd0);
        chk("async_rst_err", 64'(perr[0]), 64'd0);
        err_exp[0] = 1'b0;
        err_exp[1] = 1'b0;
        rd[0] = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        txn(0, 1'b0, 32'h0000_0040, 256'd0, 1'b0, -1, 1'b0);
        txn(1, 1'b0, 32'h0000_0100, 256'd0, 1'b0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
